uart_tx_ctrl: RTL

UART transmit controller that sequences one serial frame per accepted byte: start bit, DATA_WIDTH data bits LSB-first, optional parity bit, stop bit. It owns the baud divider and the data-bit counter and drives the serial line directly. It sits between the byte-producing logic (valid/ready source) and the TX pin.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_baud_timer.sv | 28 ++
 rtl/uart_tx_ctrl.sv | 108 ++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_baud_timer.sv
// Baud divider: counts CLKS_PER_BIT cycles per serial bit while run is high.
module uart_baud_timer #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic run,
    output logic bit_end
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge CLK) begin
        if (RST || !run) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bit_end = run && (cnt_q == CNT_MAX);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: one frame (start, data LSB-first, optional parity, stop)
// per accepted byte, driving the serial line from a register.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    output logic                  data_ready,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic                  tx_out,
    output logic                  busy
);

    localparam int unsigned BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    tx_state_e             state_q;
    logic [DATA_WIDTH-1:0] shreg_q;
    logic [BIT_W-1:0]      bit_cnt_q;
    logic                  par_en_q;
    logic                  par_bit_q;
    logic                  bit_end;

    assign data_ready = (state_q == IDLE) && !RST;

    // Timer runs only while a frame is in flight, so it is already cleared on accept.
    uart_baud_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_timer (
        .CLK    (CLK),
        .RST    (RST),
        .run    (state_q != IDLE),
        .bit_end(bit_end)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            tx_out    <= 1'b1;
            busy      <= 1'b0;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (data_valid && data_ready) begin
                        shreg_q   <= data_in;
                        par_en_q  <= par_en;
                        par_bit_q <= (par_typ == PAR_ODD) ? ~(^data_in) : ^data_in;
                        bit_cnt_q <= '0;
                        state_q   <= START;
                        tx_out    <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        tx_out  <= shreg_q[0];
                        shreg_q <= shreg_q >> 1;
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_cnt_q != LAST_BIT) begin
                            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                            tx_out    <= shreg_q[0];
                            shreg_q   <= shreg_q >> 1;
                        end else if (par_en_q) begin
                            tx_out  <= par_bit_q;
                            state_q <= PARITY;
                        end else begin
                            tx_out  <= 1'b1;
                            state_q <= STOP;
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        tx_out  <= 1'b1;
                        state_q <= STOP;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        tx_out  <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    tx_out  <= 1'b1;
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
